// File: rtl/gate_pkg.sv
// Shared definitions for the N-input gate sweeper: op codes, FSM states,
// and the behavioural reference gate used as the expected-value model.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only the low n bits of vec take part; reserved op codes evaluate to 0.
  function automatic logic ref_gate(input logic [2:0] op, input logic [7:0] vec,
                                    input int n);
    logic andR;
    logic orR;
    logic xorR;
    logic y;
    andR = 1'b1;
    orR  = 1'b0;
    xorR = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        andR = andR & vec[i];
        orR  = orR | vec[i];
        xorR = xorR ^ vec[i];
      end
    end
    case (op)
      OP_AND:  y = andR;
      OP_OR:   y = orR;
      OP_NAND: y = ~andR;
      OP_NOR:  y = ~orR;
      OP_XOR:  y = xorR;
      OP_XNOR: y = ~xorR;
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_n.sv
// Purely combinational N-input gate with a selectable function; serves as
// the sweeper's reference model and can stand alone as a gate under test.
module gate_n
  import gate_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2:0]   op_i,
  input  logic [N-1:0] vec_i,
  output logic         y_o
);

  logic [7:0] vecWide;

  always_comb begin
    vecWide = '0;
    vecWide[N-1:0] = vec_i;
    y_o = ref_gate(op_i, vecWide, N);
  end

endmodule

// File: rtl/gate_n_sweeper.sv
// Walks every input combination of an N-input gate, samples its output after
// a settle delay, records the truth table and counts mismatches against a reference.
module gate_n_sweeper
  import gate_pkg::*;
#(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            dut_d,
  output logic [N-1:0]    vec,
  output logic            busy,
  output logic            done,
  output logic [(1<<N)-1:0] tt,
  output logic [N:0]      err_cnt,
  output logic [N-1:0]    first_err,
  output logic            pass
);

  localparam int NV = 1 << N;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [N-1:0]  VEC_ONE  = N'(1);
  localparam logic [N:0]    ERR_ONE  = (N+1)'(1);

  state_e          state_q, state_d;
  logic [2:0]      opLatch_q, opLatch_d;
  logic [N-1:0]    vec_q, vec_d;
  logic [CW-1:0]   settle_q, settle_d;
  logic [NV-1:0]   tt_q, tt_d;
  logic [N:0]      errCnt_q, errCnt_d;
  logic [N-1:0]    firstErr_q, firstErr_d;
  logic            pass_q, pass_d;
  logic            refY;

  gate_n #(.N(N)) u_ref (
    .op_i  (opLatch_q),
    .vec_i (vec_q),
    .y_o   (refY)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      opLatch_q  <= '0;
      vec_q      <= '0;
      settle_q   <= '0;
      tt_q       <= '0;
      errCnt_q   <= '0;
      firstErr_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opLatch_q  <= opLatch_d;
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      tt_q       <= tt_d;
      errCnt_q   <= errCnt_d;
      firstErr_q <= firstErr_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opLatch_d  = opLatch_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    tt_d       = tt_q;
    errCnt_d   = errCnt_q;
    firstErr_d = firstErr_q;
    pass_d     = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          opLatch_d  = op;
          vec_d      = '0;
          settle_d   = '0;
          tt_d       = '0;
          errCnt_d   = '0;
          firstErr_d = '0;
          pass_d     = 1'b0;
        end
      end
      ST_RUN: begin
        // dut_d matters only on the last settle cycle of each vector.
        if (settle_q == CNT_LAST) begin
          settle_d     = '0;
          tt_d[vec_q]  = dut_d;
          if (dut_d != refY) begin
            errCnt_d = errCnt_q + ERR_ONE;
            if (errCnt_q == '0) begin
              firstErr_d = vec_q;
            end
          end
          vec_d = vec_q + VEC_ONE;
          if (vec_q == '1) begin
            state_d = ST_DONE;
            pass_d  = (errCnt_d == '0);
          end
        end else begin
          settle_d = settle_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign vec       = vec_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign tt        = tt_q;
  assign err_cnt   = errCnt_q;
  assign first_err = firstErr_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_gate_n_sweeper.sv
// Directed bench for gate_n_sweeper: table of full sweeps with a modelled
// gate under test, plus reset, settle and held-start sequences.
module tb_gate_n_sweeper;

  typedef struct {
    logic [2:0] op;
    int         mode;
    logic [7:0] expTt;
    logic [3:0] expErr;
    logic [2:0] expFirst;
    logic       expPass;
  } vector_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start1 = 1'b0;
  logic [2:0] op1 = '0;
  logic       dutD1;
  logic [2:0] vec1;
  logic       busy1, done1, pass1;
  logic [7:0] tt1;
  logic [3:0] errCnt1;
  logic [2:0] firstErr1;

  logic       start3 = 1'b0;
  logic [2:0] op3 = '0;
  logic       dutD3 = 1'b0;
  logic [2:0] vec3;
  logic       busy3, done3, pass3;
  logic [7:0] tt3;
  logic [3:0] errCnt3;
  logic [2:0] firstErr3;

  int         checks = 0;
  int         errors = 0;
  int         curMode = 0;
  logic [2:0] curOp = '0;
  vector_t    tbl[9];

  always #5 clk = ~clk;

  gate_n_sweeper #(.N(3), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .dut_d(dutD1),
    .vec(vec1), .busy(busy1), .done(done1), .tt(tt1), .err_cnt(errCnt1),
    .first_err(firstErr1), .pass(pass1)
  );

  gate_n_sweeper #(.N(3), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .op(op3), .dut_d(dutD3),
    .vec(vec3), .busy(busy3), .done(done3), .tt(tt3), .err_cnt(errCnt3),
    .first_err(firstErr3), .pass(pass3)
  );

  function automatic logic tbGate(input logic [2:0] o, input logic [2:0] v);
    case (o)
      3'd0: return &v;
      3'd1: return |v;
      3'd2: return ~&v;
      3'd3: return ~|v;
      3'd4: return ^v;
      3'd5: return ~^v;
      default: return 1'b0;
    endcase
  endfunction

  // Gate under test for the SETTLE=1 instance: 0 correct, 1 stuck-1, 2 AND gate, 3 stuck-0.
  assign dutD1 = (curMode == 0) ? tbGate(curOp, vec1) :
                 (curMode == 1) ? 1'b1 :
                 (curMode == 2) ? (&vec1) : 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", name, actual, expected);
    end
  endtask

  task automatic waitDone(output int cycles, input bit toggleOp);
    cycles = 0;
    while (!done1 && cycles < 60) begin
      if (toggleOp) op1 = op1 + 3'd1;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input int mode);
    curOp   = o;
    curMode = mode;
    op1     = o;
    start1  = 1'b1;
    @(posedge clk); #1;
    start1  = 1'b0;
    checkOutput("busy_at_accept", 32'(busy1), 32'd1);
    checkOutput("vec_at_accept", 32'(vec1), 32'd0);
  endtask

  initial begin
    int cycles;
    int busyCnt;
    int c;

    tbl[0] = '{3'd2, 0, 8'h7F, 4'd0, 3'd0, 1'b1};
    tbl[1] = '{3'd2, 1, 8'hFF, 4'd1, 3'd7, 1'b0};
    tbl[2] = '{3'd4, 2, 8'h80, 4'd3, 3'd1, 1'b0};
    tbl[3] = '{3'd0, 0, 8'h80, 4'd0, 3'd0, 1'b1};
    tbl[4] = '{3'd1, 0, 8'hFE, 4'd0, 3'd0, 1'b1};
    tbl[5] = '{3'd5, 2, 8'h80, 4'd5, 3'd0, 1'b0};
    tbl[6] = '{3'd6, 1, 8'hFF, 4'd8, 3'd0, 1'b0};
    tbl[7] = '{3'd7, 3, 8'h00, 4'd0, 3'd0, 1'b1};
    tbl[8] = '{3'd3, 3, 8'h00, 4'd1, 3'd0, 1'b0};

    #12;
    checkOutput("rst_vec", 32'(vec1), 32'd0);
    checkOutput("rst_busy", 32'(busy1), 32'd0);
    checkOutput("rst_done", 32'(done1), 32'd0);
    checkOutput("rst_tt", 32'(tt1), 32'd0);
    checkOutput("rst_err", 32'(errCnt1), 32'd0);
    checkOutput("rst_pass", 32'(pass1), 32'd0);
    checkOutput("rst_busy3", 32'(busy3), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].op, tbl[i].mode);
      waitDone(cycles, 1'b0);
      checkOutput($sformatf("t%0d_cycles", i), 32'(cycles), 32'd8);
      checkOutput($sformatf("t%0d_busy", i), 32'(busy1), 32'd0);
      checkOutput($sformatf("t%0d_vec", i), 32'(vec1), 32'd0);
      checkOutput($sformatf("t%0d_tt", i), 32'(tt1), 32'(tbl[i].expTt));
      checkOutput($sformatf("t%0d_err", i), 32'(errCnt1), 32'(tbl[i].expErr));
      checkOutput($sformatf("t%0d_first", i), 32'(firstErr1), 32'(tbl[i].expFirst));
      checkOutput($sformatf("t%0d_pass", i), 32'(pass1), 32'(tbl[i].expPass));
      @(posedge clk); #1;
      checkOutput($sformatf("t%0d_done_fall", i), 32'(done1), 32'd0);
      checkOutput($sformatf("t%0d_hold_tt", i), 32'(tt1), 32'(tbl[i].expTt));
    end

    // SETTLE=3 with a wrong output during the first two cycles of each vector.
    op3 = 3'd3;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    busyCnt = 0;
    c = 0;
    while (busy3 && c < 100) begin
      busyCnt++;
      dutD3 = ((c % 3) == 2) ? ~|vec3 : |vec3;
      @(posedge clk); #1;
      c++;
    end
    checkOutput("s3_busy_cycles", 32'(busyCnt), 32'd24);
    checkOutput("s3_done", 32'(done3), 32'd1);
    checkOutput("s3_tt", 32'(tt3), 32'h01);
    checkOutput("s3_err", 32'(errCnt3), 32'd0);
    checkOutput("s3_pass", 32'(pass3), 32'd1);
    @(posedge clk); #1;

    // Reset mid-sweep, then a fresh sweep.
    applyStimulus(3'd4, 2);
    c = 0;
    while (vec1 != 3'd4 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput("rs_reached_vec4", 32'(vec1), 32'd4);
    #1 rst = 1'b1;
    #1;
    checkOutput("rs_vec", 32'(vec1), 32'd0);
    checkOutput("rs_busy", 32'(busy1), 32'd0);
    checkOutput("rs_tt", 32'(tt1), 32'd0);
    checkOutput("rs_err", 32'(errCnt1), 32'd0);
    checkOutput("rs_first", 32'(firstErr1), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(3'd0, 0);
    waitDone(cycles, 1'b0);
    checkOutput("rs2_cycles", 32'(cycles), 32'd8);
    checkOutput("rs2_tt", 32'(tt1), 32'h80);
    checkOutput("rs2_pass", 32'(pass1), 32'd1);
    @(posedge clk); #1;

    // Start held high with op toggling during the run.
    curMode = 2;
    op1 = 3'd1;
    start1 = 1'b1;
    @(posedge clk); #1;
    checkOutput("hs_busy", 32'(busy1), 32'd1);
    waitDone(cycles, 1'b1);
    checkOutput("hs_cycles", 32'(cycles), 32'd8);
    checkOutput("hs_tt", 32'(tt1), 32'h80);
    checkOutput("hs_err", 32'(errCnt1), 32'd6);
    checkOutput("hs_first", 32'(firstErr1), 32'd1);
    checkOutput("hs_pass", 32'(pass1), 32'd0);
    op1 = 3'd0;
    @(posedge clk); #1;
    checkOutput("hs_done_ignored_busy", 32'(busy1), 32'd0);
    checkOutput("hs_done_ignored_done", 32'(done1), 32'd0);
    @(posedge clk); #1;
    checkOutput("hs_reaccept_busy", 32'(busy1), 32'd1);
    checkOutput("hs_reaccept_err", 32'(errCnt1), 32'd0);
    checkOutput("hs_reaccept_tt", 32'(tt1), 32'd0);
    waitDone(cycles, 1'b1);
    start1 = 1'b0;
    checkOutput("hs2_cycles", 32'(cycles), 32'd8);
    checkOutput("hs2_tt", 32'(tt1), 32'h80);
    checkOutput("hs2_err", 32'(errCnt1), 32'd0);
    checkOutput("hs2_pass", 32'(pass1), 32'd1);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
